// File: rtl/aud_i2s_tx.sv
// aud_i2s_tx: I2S serial transmitter for the WM8731 DAC.
// Captures a signed sample at each left-channel start and shifts it out
// MSB-first on DACDAT. The right channel repeats the held sample, or sends
// zeros when DUP_RIGHT=0. All state changes on the falling edge of BCLK.
module aud_i2s_tx #(
  parameter int DATA_W    = 16,
  parameter bit DUP_RIGHT = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_mute,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_dac_data,
  output logic              o_aud_dacdat,
  output logic              o_sample_req,
  output logic              o_active,
  output logic [15:0]       o_frame_cnt
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              lrc_reg;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic              dacdat_reg, dacdat_next;
  logic              req_reg, req_next;
  logic [15:0]       frame_cnt_reg, frame_cnt_next;

  logic              left_start;
  logic              right_start;
  logic [DATA_W-1:0] capture_val;
  logic [DATA_W-1:0] right_val;

  // Channel edges are seen one BCLK after the codec moves DACLRCK.
  assign left_start  = lrc_reg & ~i_daclrck;
  assign right_start = ~lrc_reg & i_daclrck;
  assign capture_val = i_mute ? '0 : i_dac_data;
  assign right_val   = DUP_RIGHT ? hold_reg : '0;

  // State register and datapath registers, updated on the BCLK falling edge.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      lrc_reg       <= 1'b1;
      bit_cnt_reg   <= '0;
      shreg_reg     <= '0;
      hold_reg      <= '0;
      dacdat_reg    <= 1'b0;
      req_reg       <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      lrc_reg       <= i_daclrck;
      bit_cnt_reg   <= bit_cnt_next;
      shreg_reg     <= shreg_next;
      hold_reg      <= hold_next;
      dacdat_reg    <= dacdat_next;
      req_reg       <= req_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  // Next-state logic: disable beats channel edges, channel edges beat shifting.
  // shreg holds the bits still to be sent; the MSB of a new word goes straight
  // to the output register at the edge where the word starts.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shreg_next     = shreg_reg;
    hold_next      = hold_reg;
    dacdat_next    = 1'b0;
    req_next       = 1'b0;
    frame_cnt_next = frame_cnt_reg;

    if (!i_en) begin
      state_next   = S_IDLE;
      bit_cnt_next = '0;
      shreg_next   = '0;
      hold_next    = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_SYNC;
        end
        S_SYNC, S_SEND, S_GAP: begin
          if (left_start) begin
            hold_next      = capture_val;
            shreg_next     = capture_val << 1;
            dacdat_next    = capture_val[DATA_W-1];
            bit_cnt_next   = '0;
            req_next       = 1'b1;
            frame_cnt_next = frame_cnt_reg + 16'd1;
            state_next     = S_SEND;
          end else if (right_start && state_reg != S_SYNC) begin
            shreg_next   = right_val << 1;
            dacdat_next  = right_val[DATA_W-1];
            bit_cnt_next = '0;
            state_next   = S_SEND;
          end else if (state_reg == S_SEND) begin
            if (bit_cnt_reg == LAST_BIT) begin
              state_next = S_GAP;
            end else begin
              dacdat_next  = shreg_reg[DATA_W-1];
              shreg_next   = shreg_reg << 1;
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign o_aud_dacdat = dacdat_reg;
  assign o_sample_req = req_reg;
  assign o_frame_cnt  = frame_cnt_reg;
  assign o_active     = (state_reg == S_SEND) || (state_reg == S_GAP);

endmodule

// File: tb/tb_aud_i2s_tx.sv
// tb_aud_i2s_tx: randomized bench for aud_i2s_tx against a frame-level model.
// The model describes DACDAT as "bit (t - start) of the word that started at
// edge 'start'", with starts defined by DACLRCK transitions and enable history.
module tb_aud_i2s_tx;

  localparam int DATA_W = 16;
  localparam bit DUP    = 1'b1;

  logic              i_clk = 1'b1;
  logic              i_rst = 1'b1;
  logic              i_en = 1'b0;
  logic              i_mute = 1'b0;
  logic              i_daclrck = 1'b1;
  logic [DATA_W-1:0] i_dac_data = '0;
  logic              o_aud_dacdat;
  logic              o_sample_req;
  logic              o_active;
  logic [15:0]       o_frame_cnt;

  aud_i2s_tx #(.DATA_W(DATA_W), .DUP_RIGHT(DUP)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_mute       (i_mute),
    .i_daclrck    (i_daclrck),
    .i_dac_data   (i_dac_data),
    .o_aud_dacdat (o_aud_dacdat),
    .o_sample_req (o_sample_req),
    .o_active     (o_active),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int                t_edge;
  bit                m_prev_en;
  bit                m_lrc_prev;
  bit                m_active;
  logic [DATA_W-1:0] m_word;
  logic [DATA_W-1:0] m_hold;
  int                m_start;
  logic [15:0]       m_cnt;
  bit                m_req;
  bit                exp_dat;

  // Stimulus control
  int half_len = 32;
  int ph = 0;
  bit rand_data = 1'b0;
  bit rand_mute = 1'b0;
  bit rand_en = 1'b0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t_edge, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_en  = 1'b0;
    m_lrc_prev = 1'b1;
    m_active   = 1'b0;
    m_word     = '0;
    m_hold     = '0;
    m_start    = 0;
    m_cnt      = '0;
    m_req      = 1'b0;
    exp_dat    = 1'b0;
  endtask

  // One falling edge of BCLK as seen by the model, using the inputs present now.
  task automatic model_edge();
    bit ls, rs;
    int d;
    t_edge++;
    ls    = m_lrc_prev && !i_daclrck;
    rs    = !m_lrc_prev && i_daclrck;
    m_req = 1'b0;
    if (!i_en) begin
      m_active = 1'b0;
      m_hold   = '0;
      m_word   = '0;
    end else if (ls && m_prev_en) begin
      m_hold   = i_mute ? '0 : i_dac_data;
      m_word   = m_hold;
      m_start  = t_edge;
      m_active = 1'b1;
      m_req    = 1'b1;
      m_cnt    = m_cnt + 16'd1;
      $display("capture t=%0d sample=%h frame_cnt=%0d", t_edge, m_word, m_cnt);
    end else if (rs && m_active) begin
      m_word  = DUP ? m_hold : '0;
      m_start = t_edge;
    end
    d = t_edge - m_start;
    exp_dat    = (m_active && d < DATA_W) ? m_word[DATA_W-1-d] : 1'b0;
    m_prev_en  = i_en;
    m_lrc_prev = i_daclrck;
  endtask

  // One BCLK period: model the falling edge, move DACLRCK like the codec, check.
  task automatic step();
    @(negedge i_clk);
    model_edge();
    #1;
    ph++;
    if (ph >= half_len) begin
      ph = 0;
      i_daclrck = ~i_daclrck;
      if (i_daclrck && rand_data) i_dac_data = DATA_W'($urandom);
    end
    if (rand_mute) i_mute = ($urandom_range(0, 3) == 0);
    if (rand_en) begin
      if (i_en && $urandom_range(0, 299) == 0) i_en = 1'b0;
      else if (!i_en && $urandom_range(0, 7) == 0) i_en = 1'b1;
    end
    @(posedge i_clk);
    check_val("dacdat", o_aud_dacdat, exp_dat);
    check_val("sample_req", o_sample_req, m_req);
    check_val("active", o_active, m_active);
    check_val("frame_cnt", o_frame_cnt, m_cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_req();
    for (int i = 0; i < 400; i++) begin
      step();
      if (o_sample_req) break;
    end
    check_val("req_seen", o_sample_req, 1);
  endtask

  // Asynchronous reset pulse between two falling edges.
  task automatic pulse_reset();
    #2 i_rst = 1'b1;
    #1;
    check_val("rst_dacdat", o_aud_dacdat, 0);
    check_val("rst_req", o_sample_req, 0);
    check_val("rst_active", o_active, 0);
    check_val("rst_cnt", o_frame_cnt, 0);
    model_reset();
    #1 i_rst = 1'b0;
  endtask

  initial begin
    t_edge = 0;
    model_reset();
    #2;
    check_val("init_dacdat", o_aud_dacdat, 0);
    check_val("init_req", o_sample_req, 0);
    check_val("init_active", o_active, 0);
    check_val("init_cnt", o_frame_cnt, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Full 32-BCLK frames with a fixed sample
    i_dac_data = 16'hA5C3;
    i_en = 1'b1;
    half_len = 32;
    run(64 * 6);

    // Muted capture of 7FFF, then mute raised mid-word
    i_dac_data = 16'h7FFF;
    i_mute = 1'b1;
    run(64 * 2);
    i_mute = 1'b0;
    wait_req();
    run(4);
    i_mute = 1'b1;
    run(64);
    i_mute = 1'b0;

    // Enable raised during the right half
    i_en = 1'b0;
    run(10);
    for (int i = 0; i < 100 && i_daclrck !== 1'b1; i++) run(1);
    run(3);
    i_dac_data = 16'h8001;
    i_en = 1'b1;
    run(64 * 2);

    // i_en dropped at bit 5 of a word
    wait_req();
    run(4);
    i_en = 1'b0;
    run(40);
    i_en = 1'b1;

    // Short 12-BCLK frames of FFFF for 100 frames, counting from reset
    pulse_reset();
    i_dac_data = 16'hFFFF;
    half_len = 12;
    run(24 * 101);

    // Reset in the middle of a word
    half_len = 32;
    i_dac_data = 16'hA5C3;
    wait_req();
    run(3);
    pulse_reset();
    run(64 * 3);

    // Frame counter wrap: preload 0xFFFF right after a capture
    wait_req();
    force dut.frame_cnt_reg = 16'hFFFF;
    #1 release dut.frame_cnt_reg;
    m_cnt = 16'hFFFF;
    wait_req();
    check_val("cnt_wrap", o_frame_cnt, 0);

    // Randomized segments: frame lengths, data, mute and enable
    rand_data = 1'b1;
    rand_mute = 1'b1;
    rand_en   = 1'b1;
    for (int s = 0; s < 10; s++) begin
      half_len = $urandom_range(3, 40);
      run(300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
